spawn_scheduler: RTL and testbench
==================================

// Module: spawn_scheduler
// PURPOSE
// Per-lane spawn sequencer for the yellow-car lanes. Picks which lanes launch a car each
// wave from a 3-bit random value and skips lanes whose car is still on screen. Issues a
// req/ack spawn handshake to each lane mover and times the gap between waves. Sits between
// the LFSR and the three lane movers; its spawn_req bits gate the movers' drive keycode.
// PARAMETERS
// UNIT_CYCLES     50_000_000  cycles per gap unit (1 s at 50 MHz)
// BASE_UNITS      1           gap units added to rnd for the inter-wave gap
// GAP_MIN         25_000_000  floor on any computed inter-wave gap, cycles
// RETRY_CYCLES    5_000_000   gap after a wave is skipped because all chosen lanes are busy
// WAVES_PER_LEVEL 8           completed waves per difficulty level step
// LEVEL_STEP      5_000_000   cycles removed from the gap per level
// LEVEL_MAX       15          level saturation value
// PORTS
// Clk        in   1   system clock
// Reset_n    in   1   asynchronous, active-low reset
// run        in   1   game active; 0 forces IDLE
// rnd        in   3   LFSR value; sampled only in PICK
// lane_busy  in   3   bit i=1: lane i+1 car still on screen
// spawn_ack  in   3   bit i pulse: lane i+1 accepted its spawn
// spawn_req  out  3   registered; bit i=1 requests a spawn on lane i+1
// wave_cnt   out  16  completed waves; wraps at 2^16
// level      out  4   difficulty level; saturates at LEVEL_MAX
// active     out  1   1 whenever state != IDLE
// BEHAVIOUR
// - Reset (async, Reset_n=0): state IDLE, spawn_req=0, wave_cnt=0, level=0, active=0, timer=0, lvl_waves=0.
// - Lane decode of rnd: 000->001, 001->010, 010->100, 011->011, 100->101, 101->110, 110->101, 111->011.
// - States:
//   IDLE: run=1 -> GAP, timer=BASE_UNITS*UNIT_CYCLES.
//   GAP: timer-- each cycle; timer==1 -> PICK. A GAP entered with load N lasts N cycles. Load values are always >=1.
//   PICK (1 cycle): m = decode(rnd) & ~lane_busy; rnd latched as r.
//     If m==0 -> GAP, timer=RETRY_CYCLES; no count change.
//     Otherwise spawn_req<=m and the state goes to REQ.
//   REQ: spawn_req[i] clears on spawn_ack[i]&spawn_req[i]. Acks on unrequested bits are ignored.
//     Next cycle after spawn_req reaches 0 -> GAP with:
//       * wave_cnt++;
//       * lvl_waves++; on reaching WAVES_PER_LEVEL, lvl_waves=0 and level++ (saturating).
//       * timer = max(GAP_MIN, (BASE_UNITS+r)*UNIT_CYCLES - level_new*LEVEL_STEP).
// - Gap arithmetic is 32-bit. A subtraction that underflows clamps to GAP_MIN; no wrap.
// - run=0 in any state -> IDLE next edge; spawn_req cleared the same edge.
//   Priority: run=0 beats ack and timer expiry. wave_cnt and level are held, not cleared.
// - Ack and the last pending bit clear in the same cycle: REQ exits the following edge, not earlier.
// - lane_busy is ignored outside PICK. A lane that becomes busy during REQ keeps its request.
// - Latency: PICK -> spawn_req visible 1 cycle. Last ack -> GAP 2 edges.
// CONFIGURATION
// DIFFICULTY_RAMP_EN defined: level increments as described and shortens the gap.
// Not defined: level is tied to 0, lvl_waves logic is absent, gap = max(GAP_MIN, (BASE_UNITS+r)*UNIT_CYCLES).
// TESTING (UNIT_CYCLES=10, BASE_UNITS=1, GAP_MIN=4, RETRY_CYCLES=3, WAVES_PER_LEVEL=2, LEVEL_STEP=5, LEVEL_MAX=3)
// 1 Basic launch: run=1 sampled at edge 0, rnd=011, lane_busy=000 -> spawn_req=011 from edge 11.
//   Ack both -> wave_cnt=1, GAP load 40.
// 2 Busy mask: rnd=011, lane_busy=010 at PICK -> spawn_req=001.
//   Same case with rnd=001 -> no request, GAP load 3, wave_cnt unchanged.
// 3 Split acks: req=101; ack 001 then ack 100 three cycles later -> spawn_req 101->100->000.
//   Stray ack 010 is ignored.
// 4 Ramp (DIFFICULTY_RAMP_EN): 6 waves with rnd=000 -> level 1,2,3 after waves 2,4,6.
//   Gap loads 10,5,5,4,4,4; level stays 3 after 8 waves.
//   Without the macro: level=0 and all gaps are 10.
// 5 Abort: run=0 during REQ with req=011 and a simultaneous ack -> IDLE, spawn_req=000 next edge.
//   wave_cnt unchanged.
// 6 Async reset: Reset_n=0 mid-GAP, no clock edge -> spawn_req=0, level=0, wave_cnt=0, active=0 immediately.

Source files
------------

// File: rtl/spawn_scheduler_if.sv
// Spawn handshake bundle between the scheduler and the three lane movers.
// Carries the per-lane request and acknowledge bits and the lane-occupied flags.
interface spawn_scheduler_if;
  logic [2:0] spawn_req;
  logic [2:0] spawn_ack;
  logic [2:0] lane_busy;

  modport master (output spawn_req, input spawn_ack, input lane_busy);
  modport slave  (input spawn_req, output spawn_ack, output lane_busy);
endinterface

// File: rtl/spawn_scheduler.sv
// Per-lane spawn sequencer: picks lanes from the LFSR value, hands out spawn requests
// and times the gap between waves. Optional difficulty ramp enabled by DIFFICULTY_RAMP_EN.
module spawn_scheduler #(
  parameter int unsigned UNIT_CYCLES     = 50_000_000,
  parameter int unsigned BASE_UNITS      = 1,
  parameter int unsigned GAP_MIN         = 25_000_000,
  parameter int unsigned RETRY_CYCLES    = 5_000_000,
  parameter int unsigned WAVES_PER_LEVEL = 8,
  parameter int unsigned LEVEL_STEP      = 5_000_000,
  parameter int unsigned LEVEL_MAX       = 15
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      run,
  input  logic [2:0]                rnd,
  spawn_scheduler_if.master         lanes,
  output logic [15:0]               wave_cnt,
  output logic [3:0]                level,
  output logic                      active
);

  typedef enum logic [1:0] {IDLE, GAP, PICK, REQ} state_t;

  localparam logic [31:0] UNIT_W  = 32'(UNIT_CYCLES);
  localparam logic [31:0] BASE_W  = 32'(BASE_UNITS);
  localparam logic [31:0] GAP_W   = 32'(GAP_MIN);
  localparam logic [31:0] RETRY_W = 32'(RETRY_CYCLES);
  localparam logic [31:0] STEP_W  = 32'(LEVEL_STEP);
  localparam logic [31:0] FIRST_W = BASE_W * UNIT_W;

  state_t      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [2:0]  req_q, req_d;
  logic [2:0]  r_q, r_d;
  logic [15:0] wave_q, wave_d;
  logic [2:0]  pick_mask;
  logic        wave_done;
  logic [3:0]  level_d;

  function automatic logic [2:0] decode_lanes(input logic [2:0] v);
    case (v)
      3'b000:  return 3'b001;
      3'b001:  return 3'b010;
      3'b010:  return 3'b100;
      3'b011:  return 3'b011;
      3'b100:  return 3'b101;
      3'b101:  return 3'b110;
      3'b110:  return 3'b101;
      default: return 3'b011;
    endcase
  endfunction

  // Underflow of the level cut clamps to the floor rather than wrapping.
  function automatic logic [31:0] wave_gap(input logic [2:0] r, input logic [3:0] lvl);
    logic [31:0] span;
    logic [31:0] cut;
    span = (BASE_W + 32'(r)) * UNIT_W;
    cut  = 32'(lvl) * STEP_W;
    if (cut >= span) return GAP_W;
    if ((span - cut) < GAP_W) return GAP_W;
    return span - cut;
  endfunction

  assign pick_mask = decode_lanes(rnd) & ~lanes.lane_busy;
  assign wave_done = run && (state_q == REQ) && (req_q == 3'b000);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d = state_q;
    timer_d = timer_q;
    req_d   = req_q;
    r_d     = r_q;
    wave_d  = wave_q;
    if (!run) begin
      state_d = IDLE;
      req_d   = 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = GAP;
          timer_d = FIRST_W;
        end
        GAP: begin
          timer_d = timer_q - 32'd1;
          if (timer_q <= 32'd1) state_d = PICK;
        end
        PICK: begin
          r_d = rnd;
          if (pick_mask == 3'b000) begin
            state_d = GAP;
            timer_d = RETRY_W;
          end else begin
            state_d = REQ;
            req_d   = pick_mask;
          end
        end
        REQ: begin
          if (req_q == 3'b000) begin
            state_d = GAP;
            wave_d  = wave_q + 16'd1;
            timer_d = wave_gap(r_q, level_d);
          end else begin
            req_d = req_q & ~lanes.spawn_ack;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      req_q   <= '0;
      r_q     <= '0;
      wave_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      req_q   <= req_d;
      r_q     <= r_d;
      wave_q  <= wave_d;
    end
  end

`ifdef DIFFICULTY_RAMP_EN
  localparam int unsigned LW = (WAVES_PER_LEVEL > 1) ? $clog2(WAVES_PER_LEVEL) : 1;

  logic [3:0]    level_q;
  logic [LW-1:0] lvl_waves_q, lvl_waves_d;

  always_comb begin
    level_d     = level_q;
    lvl_waves_d = lvl_waves_q;
    if (wave_done) begin
      if (lvl_waves_q == LW'(WAVES_PER_LEVEL - 1)) begin
        lvl_waves_d = '0;
        if (level_q < 4'(LEVEL_MAX)) level_d = level_q + 4'd1;
      end else begin
        lvl_waves_d = lvl_waves_q + LW'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      level_q     <= '0;
      lvl_waves_q <= '0;
    end else begin
      level_q     <= level_d;
      lvl_waves_q <= lvl_waves_d;
    end
  end

  assign level = level_q;
`else
  assign level_d = 4'd0;
  assign level   = 4'd0;
`endif

  assign lanes.spawn_req = req_q;
  assign wave_cnt        = wave_q;
  assign active          = (state_q != IDLE);

endmodule

// File: tb/tb_spawn_scheduler.sv
// Directed bench for spawn_scheduler with small timing parameters; expected values
// are hand-computed and cover both builds of DIFFICULTY_RAMP_EN.
module tb_spawn_scheduler;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        run = 1'b0;
  logic [2:0]  rnd = 3'b000;
  logic [15:0] wave_cnt;
  logic [3:0]  level;
  logic        active;
  int          n_checks = 0;
  int          n_fail = 0;

  spawn_scheduler_if bus ();

  spawn_scheduler #(
    .UNIT_CYCLES(10), .BASE_UNITS(1), .GAP_MIN(4), .RETRY_CYCLES(3),
    .WAVES_PER_LEVEL(2), .LEVEL_STEP(5), .LEVEL_MAX(3)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .run(run), .rnd(rnd), .lanes(bus.master),
    .wave_cnt(wave_cnt), .level(level), .active(active)
  );

  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    run = 1'b0;
    rnd = 3'b000;
    bus.spawn_ack = 3'b000;
    bus.lane_busy = 3'b000;
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
  endtask

  // Returns edges until spawn_req goes non-zero, or -1 when the bound expires.
  task automatic wait_req(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (bus.spawn_req !== 3'b000) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    run = 1'b0;
    bus.spawn_ack = 3'b000;
    bus.lane_busy = 3'b000;
    Reset_n = 1'b0;
    #3;
    n_checks++;
    if (bus.spawn_req !== 3'b000) begin n_fail++; $display("FAIL reset_req: got %b want 000", bus.spawn_req); end
    n_checks++;
    if (wave_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_wave: got %0d want 0", wave_cnt); end
    n_checks++;
    if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
    n_checks++;
    if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", active); end
  endtask

  task automatic test_basic_launch();
    int c;
    do_reset();
    rnd = 3'b011;
    run = 1'b1;
    tick();
    n_checks++;
    if (active !== 1'b1) begin n_fail++; $display("FAIL basic_active: got %b want 1", active); end
    repeat (10) tick();
    n_checks++;
    if (bus.spawn_req !== 3'b000) begin n_fail++; $display("FAIL basic_early: got %b want 000 at edge 10", bus.spawn_req); end
    tick();
    n_checks++;
    if (bus.spawn_req !== 3'b011) begin n_fail++; $display("FAIL basic_req: got %b want 011 at edge 11", bus.spawn_req); end
    bus.spawn_ack = 3'b011;
    tick();
    bus.spawn_ack = 3'b000;
    n_checks++;
    if (bus.spawn_req !== 3'b000 || wave_cnt !== 16'd0) begin
      n_fail++; $display("FAIL basic_ack: req %b wave %0d want 000 and 0", bus.spawn_req, wave_cnt);
    end
    tick();
    n_checks++;
    if (wave_cnt !== 16'd1) begin n_fail++; $display("FAIL basic_wave: got %0d want 1", wave_cnt); end
    wait_req(c);
    n_checks++;
    if (c != 41) begin n_fail++; $display("FAIL basic_gap: got %0d edges want 41 (load 40)", c); end
  endtask

  task automatic test_busy_mask();
    do_reset();
    rnd = 3'b011;
    bus.lane_busy = 3'b010;
    run = 1'b1;
    repeat (12) tick();
    n_checks++;
    if (bus.spawn_req !== 3'b001) begin n_fail++; $display("FAIL mask_partial: got %b want 001", bus.spawn_req); end

    do_reset();
    rnd = 3'b001;
    bus.lane_busy = 3'b010;
    run = 1'b1;
    repeat (12) tick();
    n_checks++;
    if (bus.spawn_req !== 3'b000 || active !== 1'b1) begin
      n_fail++; $display("FAIL mask_skip: req %b active %b want 000 and 1", bus.spawn_req, active);
    end
    bus.lane_busy = 3'b000;
    repeat (3) tick();
    n_checks++;
    if (bus.spawn_req !== 3'b000) begin n_fail++; $display("FAIL retry_early: got %b want 000 at edge 14", bus.spawn_req); end
    tick();
    n_checks++;
    if (bus.spawn_req !== 3'b010 || wave_cnt !== 16'd0) begin
      n_fail++; $display("FAIL retry_req: req %b wave %0d want 010 and 0", bus.spawn_req, wave_cnt);
    end
    bus.lane_busy = 3'b111;
    repeat (3) tick();
    n_checks++;
    if (bus.spawn_req !== 3'b010) begin n_fail++; $display("FAIL busy_in_req: got %b want 010", bus.spawn_req); end
  endtask

  task automatic test_split_ack();
    int c;
    do_reset();
    rnd = 3'b100;
    run = 1'b1;
    repeat (12) tick();
    n_checks++;
    if (bus.spawn_req !== 3'b101) begin n_fail++; $display("FAIL split_req: got %b want 101", bus.spawn_req); end
    bus.spawn_ack = 3'b001;
    tick();
    n_checks++;
    if (bus.spawn_req !== 3'b100) begin n_fail++; $display("FAIL split_first: got %b want 100", bus.spawn_req); end
    bus.spawn_ack = 3'b000;
    tick();
    bus.spawn_ack = 3'b010;
    tick();
    n_checks++;
    if (bus.spawn_req !== 3'b100) begin n_fail++; $display("FAIL split_stray: got %b want 100", bus.spawn_req); end
    bus.spawn_ack = 3'b100;
    tick();
    bus.spawn_ack = 3'b000;
    n_checks++;
    if (bus.spawn_req !== 3'b000 || wave_cnt !== 16'd0) begin
      n_fail++; $display("FAIL split_last: req %b wave %0d want 000 and 0", bus.spawn_req, wave_cnt);
    end
    tick();
    n_checks++;
    if (wave_cnt !== 16'd1) begin n_fail++; $display("FAIL split_wave: got %0d want 1", wave_cnt); end
    wait_req(c);
    n_checks++;
    if (c != 51) begin n_fail++; $display("FAIL split_gap: got %0d edges want 51 (load 50)", c); end
  endtask

  task automatic test_ramp();
    int c;
    int exp_lvl[8];
    int exp_gap[8];
`ifdef DIFFICULTY_RAMP_EN
    exp_lvl = '{0, 1, 1, 2, 2, 3, 3, 3};
    exp_gap = '{10, 5, 5, 4, 4, 4, 4, 4};
`else
    exp_lvl = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_gap = '{10, 10, 10, 10, 10, 10, 10, 10};
`endif
    do_reset();
    rnd = 3'b000;
    run = 1'b1;
    tick();
    wait_req(c);
    n_checks++;
    if (c != 11) begin n_fail++; $display("FAIL ramp_first: got %0d edges want 11", c); end
    for (int w = 0; w < 8; w++) begin
      bus.spawn_ack = 3'b001;
      tick();
      bus.spawn_ack = 3'b000;
      tick();
      n_checks++;
      if (wave_cnt !== 16'(w + 1) || level !== 4'(exp_lvl[w])) begin
        n_fail++;
        $display("FAIL ramp_wave%0d: wave %0d level %0d want %0d and %0d", w + 1, wave_cnt, level, w + 1, exp_lvl[w]);
      end
      if (w < 7) begin
        wait_req(c);
        n_checks++;
        if (c != exp_gap[w] + 1) begin
          n_fail++; $display("FAIL ramp_gap%0d: got %0d edges want %0d", w + 1, c, exp_gap[w] + 1);
        end
      end
    end
  endtask

  task automatic test_abort();
    int c;
    do_reset();
    rnd = 3'b011;
    run = 1'b1;
    repeat (12) tick();
    bus.spawn_ack = 3'b011;
    tick();
    bus.spawn_ack = 3'b000;
    tick();
    wait_req(c);
    n_checks++;
    if (c != 41 || bus.spawn_req !== 3'b011) begin
      n_fail++; $display("FAIL abort_setup: edges %0d req %b want 41 and 011", c, bus.spawn_req);
    end
    bus.spawn_ack = 3'b011;
    run = 1'b0;
    tick();
    bus.spawn_ack = 3'b000;
    n_checks++;
    if (bus.spawn_req !== 3'b000 || active !== 1'b0 || wave_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL abort: req %b active %b wave %0d want 000 0 1", bus.spawn_req, active, wave_cnt);
    end
    repeat (3) tick();
    n_checks++;
    if (active !== 1'b0 || wave_cnt !== 16'd1) begin
      n_fail++; $display("FAIL abort_hold: active %b wave %0d want 0 and 1", active, wave_cnt);
    end
  endtask

  task automatic test_async_reset();
    int c;
    do_reset();
    rnd = 3'b000;
    run = 1'b1;
    tick();
    wait_req(c);
    bus.spawn_ack = 3'b001;
    tick();
    bus.spawn_ack = 3'b000;
    tick();
    n_checks++;
    if (c != 11 || wave_cnt !== 16'd1) begin
      n_fail++; $display("FAIL areset_setup: edges %0d wave %0d want 11 and 1", c, wave_cnt);
    end
    repeat (3) tick();
    #2;
    Reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.spawn_req !== 3'b000 || level !== 4'd0 || wave_cnt !== 16'd0 || active !== 1'b0) begin
      n_fail++;
      $display("FAIL areset: req %b level %0d wave %0d active %b want 000 0 0 0", bus.spawn_req, level, wave_cnt, active);
    end
    run = 1'b0;
    #2;
    Reset_n = 1'b1;
  endtask

  initial begin
    bus.spawn_ack = 3'b000;
    bus.lane_busy = 3'b000;
    test_reset();
    test_basic_launch();
    test_busy_mask();
    test_split_ack();
    test_ramp();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
